// File: rtl/xrv_id.sv
// xrv_id: instruction decode stage of the xriscv core.
// Accepts one expanded 32-bit instruction per fetch handshake, registers its
// decoded fields and issues it to execute with a single-cycle ex_valid strobe.
// Loads/stores hold the stage until ls_done so execute can still read
// dest/funct3 at writeback; an execute redirect squashes the issuing slot.
module xrv_id #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        if_compressed,
    input  logic        ex_jmp,
    input  logic        ls_done,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic        op_lui,
    output logic        op_auipc,
    output logic        op_jal,
    output logic        op_jalr,
    output logic        op_branch,
    output logic        op_load,
    output logic        op_store,
    output logic        op_imm,
    output logic        op_reg,
    output logic        op_is_compressed,
    output logic [31:0] imm_signed,
    output logic [31:0] imm_unsigned,
    output logic [4:0]  src1,
    output logic [4:0]  src2,
    output logic [4:0]  dest,
    output logic        funct3_is_0,
    output logic        funct3_is_1,
    output logic        funct3_is_2,
    output logic        funct3_is_3,
    output logic        funct3_is_4,
    output logic        funct3_is_5,
    output logic        funct3_is_6,
    output logic        funct3_is_7,
    output logic        funct7_bit5,
    output logic        id_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_LS_WAIT = 2'd2
    } state_t;

    // Bit positions inside the one-hot opcode vector.
    localparam int OP_LUI    = 0;
    localparam int OP_AUIPC  = 1;
    localparam int OP_JAL    = 2;
    localparam int OP_JALR   = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_LOAD   = 5;
    localparam int OP_STORE  = 6;
    localparam int OP_IMM    = 7;
    localparam int OP_REG    = 8;

    state_t      state_reg, state_next;
    logic [8:0]  op_reg_vec, op_next;
    logic        illegal_reg, illegal_next;
    logic [31:0] imm_s_reg, imm_s_next;
    logic [31:0] imm_u_reg, imm_u_next;
    logic [31:0] pc_reg;
    logic [4:0]  src1_reg, src2_reg, dest_reg;
    logic [7:0]  f3_reg, f3_next;
    logic        f7_reg, comp_reg;
    logic        accept;
    logic        ls_issue;

    // The issuing instruction is a memory op that must wait for ls_done.
    assign ls_issue = op_reg_vec[OP_LOAD] | op_reg_vec[OP_STORE];
    assign if_ready = ~rst & ~ex_jmp &
                      ((state_reg == ST_EMPTY) | ((state_reg == ST_ISSUE) & ~ls_issue));
    assign accept   = if_valid & if_ready;

    // Opcode classification and format-dependent signed immediate.
    always_comb begin
        op_next      = '0;
        illegal_next = 1'b0;
        imm_s_next   = '0;
        if (if_instr[1:0] != 2'b11) begin
            illegal_next = 1'b1;
        end else begin
            case (if_instr[6:2])
                5'b01101: begin
                    op_next[OP_LUI] = 1'b1;
                    imm_s_next      = {if_instr[31:12], 12'h000};
                end
                5'b00101: begin
                    op_next[OP_AUIPC] = 1'b1;
                    imm_s_next        = {if_instr[31:12], 12'h000};
                end
                5'b11011: begin
                    op_next[OP_JAL] = 1'b1;
                    imm_s_next      = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                                       if_instr[30:21], 1'b0};
                end
                5'b11001: begin
                    op_next[OP_JALR] = 1'b1;
                    imm_s_next       = {{20{if_instr[31]}}, if_instr[31:20]};
                end
                5'b11000: begin
                    op_next[OP_BRANCH] = 1'b1;
                    imm_s_next         = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25],
                                          if_instr[11:8], 1'b0};
                end
                5'b00000: begin
                    op_next[OP_LOAD] = 1'b1;
                    imm_s_next       = {{20{if_instr[31]}}, if_instr[31:20]};
                end
                5'b01000: begin
                    op_next[OP_STORE] = 1'b1;
                    imm_s_next        = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                end
                5'b00100: begin
                    op_next[OP_IMM] = 1'b1;
                    imm_s_next      = {{20{if_instr[31]}}, if_instr[31:20]};
                end
                5'b01100: begin
                    op_next[OP_REG] = 1'b1;
                end
                5'b00011, 5'b11100: begin
                    // FENCE / SYSTEM pass through as a nop: no flags, not illegal.
                    op_next = '0;
                end
                default: begin
                    illegal_next = 1'b1;
                end
            endcase
        end
    end

    // SLTIU compares against the sign-extended immediate treated as unsigned.
    assign imm_u_next = {{20{if_instr[31]}}, if_instr[31:20]};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_f3
            assign f3_next[gi] = (if_instr[14:12] == 3'(gi));
        end
    endgenerate

    // Issue/stall sequencing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (accept)                   state_next = ST_ISSUE;
                else if (ls_issue & ~ex_jmp)  state_next = ST_LS_WAIT;
                else                          state_next = ST_EMPTY;
            end
            ST_LS_WAIT: begin
                if (ls_done) state_next = ST_EMPTY;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_EMPTY;
        else     state_reg <= state_next;
    end

    // Decoded fields load only on an accepted transfer and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg_vec  <= '0;
            illegal_reg <= 1'b0;
            imm_s_reg   <= '0;
            imm_u_reg   <= '0;
            pc_reg      <= RESET_PC;
            src1_reg    <= '0;
            src2_reg    <= '0;
            dest_reg    <= '0;
            f3_reg      <= '0;
            f7_reg      <= 1'b0;
            comp_reg    <= 1'b0;
        end else if (accept) begin
            op_reg_vec  <= op_next;
            illegal_reg <= illegal_next;
            imm_s_reg   <= imm_s_next;
            imm_u_reg   <= imm_u_next;
            pc_reg      <= if_pc;
            src1_reg    <= if_instr[19:15];
            src2_reg    <= if_instr[24:20];
            dest_reg    <= if_instr[11:7];
            f3_reg      <= f3_next;
            f7_reg      <= if_instr[30];
            comp_reg    <= if_compressed;
        end
    end

    assign ex_valid         = (state_reg == ST_ISSUE);
    assign id_illegal       = ex_valid & illegal_reg;
    assign ex_pc            = pc_reg;
    assign op_lui           = op_reg_vec[OP_LUI];
    assign op_auipc         = op_reg_vec[OP_AUIPC];
    assign op_jal           = op_reg_vec[OP_JAL];
    assign op_jalr          = op_reg_vec[OP_JALR];
    assign op_branch        = op_reg_vec[OP_BRANCH];
    assign op_load          = op_reg_vec[OP_LOAD];
    assign op_store         = op_reg_vec[OP_STORE];
    assign op_imm           = op_reg_vec[OP_IMM];
    assign op_reg           = op_reg_vec[OP_REG];
    assign op_is_compressed = comp_reg;
    assign imm_signed       = imm_s_reg;
    assign imm_unsigned     = imm_u_reg;
    assign src1             = src1_reg;
    assign src2             = src2_reg;
    assign dest             = dest_reg;
    assign funct3_is_0      = f3_reg[0];
    assign funct3_is_1      = f3_reg[1];
    assign funct3_is_2      = f3_reg[2];
    assign funct3_is_3      = f3_reg[3];
    assign funct3_is_4      = f3_reg[4];
    assign funct3_is_5      = f3_reg[5];
    assign funct3_is_6      = f3_reg[6];
    assign funct3_is_7      = f3_reg[7];
    assign funct7_bit5      = f7_reg;

endmodule

// File: tb/tb_xrv_id.sv
// tb_xrv_id: directed bench for the decode stage with a behavioural
// reference model checked every cycle plus hand-computed spot checks.
module tb_xrv_id;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, if_compressed, ex_jmp, ls_done;
    logic [31:0] if_instr, if_pc;
    logic        ex_valid, op_lui, op_auipc, op_jal, op_jalr, op_branch, op_load;
    logic        op_store, op_imm, op_reg, op_is_compressed, funct7_bit5, id_illegal;
    logic [31:0] ex_pc, imm_signed, imm_unsigned;
    logic [4:0]  src1, src2, dest;
    logic        funct3_is_0, funct3_is_1, funct3_is_2, funct3_is_3;
    logic        funct3_is_4, funct3_is_5, funct3_is_6, funct3_is_7;

    int errors = 0;
    int checks = 0;

    xrv_id #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .if_compressed(if_compressed),
        .ex_jmp(ex_jmp), .ls_done(ls_done), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .op_lui(op_lui), .op_auipc(op_auipc), .op_jal(op_jal), .op_jalr(op_jalr),
        .op_branch(op_branch), .op_load(op_load), .op_store(op_store),
        .op_imm(op_imm), .op_reg(op_reg), .op_is_compressed(op_is_compressed),
        .imm_signed(imm_signed), .imm_unsigned(imm_unsigned),
        .src1(src1), .src2(src2), .dest(dest),
        .funct3_is_0(funct3_is_0), .funct3_is_1(funct3_is_1),
        .funct3_is_2(funct3_is_2), .funct3_is_3(funct3_is_3),
        .funct3_is_4(funct3_is_4), .funct3_is_5(funct3_is_5),
        .funct3_is_6(funct3_is_6), .funct3_is_7(funct3_is_7),
        .funct7_bit5(funct7_bit5), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    wire [8:0] dut_op = {op_reg, op_imm, op_store, op_load, op_branch,
                         op_jalr, op_jal, op_auipc, op_lui};
    wire [7:0] dut_f3 = {funct3_is_7, funct3_is_6, funct3_is_5, funct3_is_4,
                         funct3_is_3, funct3_is_2, funct3_is_1, funct3_is_0};

    typedef struct packed {
        logic [8:0]  op;   // [0]lui [1]auipc [2]jal [3]jalr [4]branch [5]load [6]store [7]imm [8]reg
        logic        ill;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        logic [31:0] pc;
        logic [4:0]  s1, s2, d;
        logic [7:0]  f3;
        logic        f7;
        logic        c;
    } dec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA field layout.
    function automatic dec_t decode(input logic [31:0] w, input logic [31:0] pc, input logic c);
        dec_t r;
        int   v;
        r       = '0;
        r.pc    = pc;
        r.c     = c;
        r.s1    = w[19:15];
        r.s2    = w[24:20];
        r.d     = w[11:7];
        r.f3    = 8'd1 << w[14:12];
        r.f7    = w[30];
        v       = $signed(w[31:20]);
        r.imm_u = v;
        case (w[6:0])
            7'h37: begin r.op[0] = 1'b1; r.imm_s = w & 32'hFFFF_F000; end
            7'h17: begin r.op[1] = 1'b1; r.imm_s = w & 32'hFFFF_F000; end
            7'h6F: begin r.op[2] = 1'b1;
                         v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); r.imm_s = v; end
            7'h67: begin r.op[3] = 1'b1; v = $signed(w[31:20]); r.imm_s = v; end
            7'h63: begin r.op[4] = 1'b1;
                         v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); r.imm_s = v; end
            7'h03: begin r.op[5] = 1'b1; v = $signed(w[31:20]); r.imm_s = v; end
            7'h23: begin r.op[6] = 1'b1; v = $signed({w[31:25], w[11:7]}); r.imm_s = v; end
            7'h13: begin r.op[7] = 1'b1; v = $signed(w[31:20]); r.imm_s = v; end
            7'h33: r.op[8] = 1'b1;
            7'h0F, 7'h73: r.op = '0;
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Model state: is something issuing now, is a memory op outstanding.
    dec_t m_dec;
    logic m_issue = 1'b0;
    logic m_lsw   = 1'b0;
    logic chk_en  = 1'b0;

    function automatic logic exp_ready();
        return !rst && !ex_jmp && !m_lsw && !(m_issue && (m_dec.op[5] || m_dec.op[6]));
    endfunction

    // Reference model advance.
    always @(posedge clk) begin
        logic acc;
        if (rst) begin
            m_issue <= 1'b0;
            m_lsw   <= 1'b0;
            m_dec   <= '{op: '0, ill: 1'b0, imm_s: '0, imm_u: '0, pc: RST_PC,
                         s1: '0, s2: '0, d: '0, f3: '0, f7: 1'b0, c: 1'b0};
            chk_en  <= 1'b1;
        end else begin
            acc = if_valid && exp_ready();
            if (m_lsw) m_lsw <= !ls_done;
            else       m_lsw <= m_issue && (m_dec.op[5] || m_dec.op[6]) && !ex_jmp;
            m_issue <= acc;
            if (acc) m_dec <= decode(if_instr, if_pc, if_compressed);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("if_ready", if_ready, exp_ready());
            chk("ex_valid", ex_valid, m_issue);
            chk("id_illegal", id_illegal, m_issue & m_dec.ill);
            chk("ex_pc", ex_pc, m_dec.pc);
            chk("op_flags", dut_op, m_dec.op);
            chk("imm_signed", imm_signed, m_dec.imm_s);
            chk("imm_unsigned", imm_unsigned, m_dec.imm_u);
            chk("regs", {src1, src2, dest}, {m_dec.s1, m_dec.s2, m_dec.d});
            chk("funct3", dut_f3, m_dec.f3);
            chk("funct7_bit5", funct7_bit5, m_dec.f7);
            chk("compressed", op_is_compressed, m_dec.c);
            if (ex_valid)
                $display("issue pc=%h op=%b imm=%h ill=%0d", ex_pc, dut_op, imm_signed, id_illegal);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] pc, input logic c);
        if_valid      = 1'b1;
        if_instr      = w;
        if_pc         = pc;
        if_compressed = c;
    endtask

    logic [31:0] tbl_w [8] = '{32'h0000007F, 32'h0FF0000F, 32'h00000073, 32'h00000001,
                               32'h40315093, 32'h402081B3, 32'h000280E7, 32'hFFF0B213};
    logic        tbl_ill [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        if_compressed = 1'b0; ex_jmp = 1'b0; ls_done = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("lit_rst_ex_valid", ex_valid, 1'b0);
        chk("lit_rst_pc", ex_pc, RST_PC);
        chk("lit_rst_ready", if_ready, 1'b0);

        // addi x5,x1,-3
        tick(); rst = 1'b0; drive(32'hFFD08293, 32'h200, 1'b0);
        tick(); if_valid = 1'b0;
        @(negedge clk);
        chk("lit_addi_valid", ex_valid, 1'b1);
        chk("lit_addi_op", op_imm, 1'b1);
        chk("lit_addi_imm", imm_signed, 32'hFFFFFFFD);
        chk("lit_addi_src1", src1, 5'd1);
        chk("lit_addi_dest", dest, 5'd5);
        chk("lit_addi_f3", funct3_is_0, 1'b1);

        // lui / auipc / jal / beq back to back
        tick(); drive(32'h123452B7, 32'h204, 1'b0);
        tick(); drive(32'h00001317, 32'h208, 1'b0);
        @(negedge clk); chk("lit_lui_imm", imm_signed, 32'h12345000);
        tick(); drive(32'h010000EF, 32'h20C, 1'b1);
        tick(); drive(32'hFE000CE3, 32'h20E, 1'b0);
        @(negedge clk); chk("lit_jal_imm", imm_signed, 32'h00000010);
        tick(); drive(32'hFFD08293, 32'h400, 1'b0); ex_jmp = 1'b1;
        @(negedge clk);
        chk("lit_beq_valid", ex_valid, 1'b1);
        chk("lit_beq_imm", imm_signed, 32'hFFFFFFF8);
        chk("lit_jmp_ready", if_ready, 1'b0);
        tick(); ex_jmp = 1'b0; if_valid = 1'b0;
        @(negedge clk); chk("lit_jmp_squash", ex_valid, 1'b0);

        // sw x5,8(x1) squashed by redirect: never waits for ls_done
        tick(); drive(32'h0050A423, 32'h500, 1'b0);
        tick(); if_valid = 1'b0; ex_jmp = 1'b1;
        @(negedge clk); chk("lit_sw_imm", imm_signed, 32'h00000008);
        tick(); ex_jmp = 1'b0;
        @(negedge clk); chk("lit_sw_nowait", if_ready, 1'b1);

        // lw x3,4(x2) then addi: stall until ls_done at +5
        tick(); drive(32'h00412183, 32'h600, 1'b0);
        tick(); drive(32'hFFD08293, 32'h300, 1'b0);
        @(negedge clk);
        chk("lit_lw_valid", op_load & ex_valid, 1'b1);
        chk("lit_lw_ready", if_ready, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge clk);
            chk("lit_lw_stall", if_ready, 1'b0);
            chk("lit_lw_dest", dest, 5'd3);
        end
        tick(); ls_done = 1'b1;
        tick(); ls_done = 1'b0;
        @(negedge clk); chk("lit_lw_release", if_ready, 1'b1);
        tick(); if_valid = 1'b0;
        @(negedge clk);
        chk("lit_addi2_valid", ex_valid, 1'b1);
        chk("lit_addi2_pc", ex_pc, 32'h300);

        // stray ls_done while idle
        tick(); ls_done = 1'b1;
        tick(); ls_done = 1'b0;

        // illegal / nop / misc encodings
        for (int i = 0; i < 8; i++) begin
            tick(); drive(tbl_w[i], 32'h700 + 32'(4 * i), 1'(i));
            tick(); if_valid = 1'b0;
            @(negedge clk);
            chk("lit_tbl_valid", ex_valid, 1'b1);
            chk("lit_tbl_illegal", id_illegal, tbl_ill[i]);
            if (tbl_ill[i]) chk("lit_tbl_noop", dut_op, 9'd0);
        end

        // reset pulse during a store stall; pending ls_done ignored
        tick(); drive(32'h0050A423, 32'h800, 1'b0);
        tick(); if_valid = 1'b0;
        tick();
        tick(); rst = 1'b1;
        @(negedge clk); chk("lit_rst2_ready", if_ready, 1'b0);
        tick(); rst = 1'b0; ls_done = 1'b1;
        @(negedge clk);
        chk("lit_rst2_pc", ex_pc, RST_PC);
        chk("lit_rst2_store", op_store, 1'b0);
        chk("lit_rst2_ready", if_ready, 1'b1);
        tick(); ls_done = 1'b0;
        @(negedge clk); chk("lit_rst2_ready2", if_ready, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xrv_id.md
# xrv_id

Instruction decode stage of the xriscv core, directly upstream of the execute stage. It accepts one 32-bit instruction word per handshake from fetch and decodes it into registered one-hot opcode flags, immediates, register indices and one-hot funct3 strobes. It presents one single-cycle `ex_valid` issue per instruction. It stalls fetch while a load/store is in flight and drops the issued instruction when execute redirects.

## Interface
Parameters:
- `RESET_PC`, 32'h0: value of `ex_pc` after reset.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `if_valid` in 1: fetch presents an instruction.
- `if_ready` out 1: decode accepts. A transfer occurs when `if_valid & if_ready`.
- `if_instr` in 32: instruction word. Compressed instructions arrive already expanded.
- `if_pc` in 32: address of `if_instr`.
- `if_compressed` in 1: the instruction came from a 16-bit encoding.
- `ex_jmp` in 1: execute redirect, registered in execute.
- `ls_done` in 1: load writeback or store acceptance pulse.
- `ex_valid` out 1: single-cycle issue strobe.
- `ex_pc` out 32: PC of the decoded instruction.
- `op_lui`, `op_auipc`, `op_jal`, `op_jalr`, `op_branch`, `op_load`, `op_store`, `op_imm`, `op_reg` out 1 each: one-hot opcode flags, or all zero.
- `op_is_compressed` out 1: registered copy of `if_compressed`.
- `imm_signed` out 32: type-dependent immediate.
- `imm_unsigned` out 32: immediate for SLTIU.
- `src1`, `src2`, `dest` out 5 each: `instr[19:15]`, `instr[24:20]`, `instr[11:7]`.
- `funct3_is_0` … `funct3_is_7` out 1 each: one-hot decode of `instr[14:12]`.
- `funct7_bit5` out 1: `instr[30]`.
- `id_illegal` out 1: pulses with `ex_valid` on an unsupported encoding.

## Operation
- All decoded outputs are registers. They load only on an accepted transfer and hold otherwise, including through an LS_WAIT stall.
- Opcode decode uses `instr[6:2]` with `instr[1:0]==2'b11`:
  - 01101 → lui; 00101 → auipc; 11011 → jal; 11001 → jalr; 11000 → branch.
  - 00000 → load; 01000 → store; 00100 → imm; 01100 → reg.
  - 00011 (FENCE) and 11100 (SYSTEM) decode as a nop: all flags 0, no illegal.
  - Any other encoding: all flags 0 and `id_illegal=1`.
- `imm_signed` by format:
  - I-type (jalr/load/imm): `sext(instr[31:20])`.
  - S-type: `sext({instr[31:25],instr[11:7]})`.
  - B-type: `sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})`.
  - U-type: `{instr[31:12],12'h0}`.
  - J-type: `sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})`.
  - Others: 0.
- `imm_unsigned` = `sext(instr[31:20])`. SLTIU compares unsigned after sign extension.
- For op_imm shifts (funct3 1/5), `funct7_bit5` carries `instr[30]`. `imm_signed[4:0]` is the shift amount.
- FSM states:
  - EMPTY: nothing issued.
  - ISSUE: `ex_valid=1` for exactly this cycle.
  - LS_WAIT: load/store outstanding.
- Transitions:
  - EMPTY/ISSUE with an accept → ISSUE.
  - ISSUE with `op_load|op_store` and `~ex_jmp` → LS_WAIT.
  - ISSUE otherwise, with no accept → EMPTY.
  - LS_WAIT with `ls_done` → EMPTY.
- `if_ready = ~rst & ~ex_jmp & (state==EMPTY | (state==ISSUE & ~op_load & ~op_store))`.

## Timing
- Reset values:
  - State EMPTY.
  - `ex_valid`, `id_illegal`, all `op_*`, all `funct3_is_*`, `funct7_bit5`, `op_is_compressed` = 0.
  - `imm_*` = 0 and `src1`/`src2`/`dest` = 0.
  - `ex_pc` = `RESET_PC`.
  - `if_ready` = 0 while `rst` is high.
- Latency: accept at cycle N gives `ex_valid` at N+1. Back-to-back non-LS instructions sustain one issue per cycle.
- Redirect:
  - While `ex_jmp=1`, `if_ready=0`.
  - An instruction in ISSUE during `ex_jmp` is squashed by execute. It never enters LS_WAIT, even if it is a load/store.
  - The FSM returns to EMPTY. The next accept is the redirect target.
- Load/store:
  - Fields hold stable from ISSUE through the `ls_done` cycle, because execute uses `dest`/funct3 at writeback.
  - `if_ready` rises the cycle after `ls_done`. The next issue is therefore ≥2 cycles after `ls_done`.
- `ls_done` outside LS_WAIT is ignored.
- `rst` asserted mid-stall returns to EMPTY next edge. A pending `ls_done` is then ignored.

## Test plan
- Reset, then `if_valid=1` with `addi x5,x1,-3` (32'hFFD08293) → next cycle `ex_valid=1`, `op_imm=1`, `imm_signed=32'hFFFFFFFD`, `src1=1`, `dest=5`, `funct3_is_0=1`.
- Stream lui/auipc/jal/branch words on consecutive cycles → four consecutive `ex_valid` pulses with correct U/J/B immediates. `beq x0,x0,-8` (32'hFE000CE3) gives `imm_signed=32'hFFFFFFF8`.
- Sequence:
  - `lw x3,4(x2)` followed by an addi → `ex_valid` pulse.
  - `if_ready=0` and fields frozen until `ls_done` at cycle +5.
  - `if_ready=1` at +6, and the addi issues at +7.
- Branch in ISSUE with `ex_jmp=1` on the following cycle → `if_ready=0` that cycle. A store sitting in ISSUE during `ex_jmp` does not enter LS_WAIT.
- Illegal word 32'h0000007F → `ex_valid=1`, `id_illegal=1`, all `op_*`=0. `fence` (32'h0FF0000F) → `ex_valid=1`, `id_illegal=0`.
- `rst` pulse during LS_WAIT → outputs return to reset values next cycle, and `if_ready=1` the cycle after `rst` drops.
